// File: rtl/jmp_pkg.sv
// Shared types and constants for the jump-control block: condition codes,
// FSM states and flag-bit positions.
package jmp_pkg;

    typedef enum logic [3:0] {
        ALWAYS = 4'h0,
        LT     = 4'h1,
        LE     = 4'h2,
        GT     = 4'h3,
        GE     = 4'h4,
        EQ     = 4'h5,
        NE     = 4'h6,
        LTU    = 4'h7,
        GEU    = 4'h8,
        NEVER  = 4'hF
    } cond_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int unsigned FLAG_Z  = 0;
    localparam int unsigned FLAG_S  = 1;
    localparam int unsigned FLAG_C  = 2;
    localparam int unsigned FLAGS_W = 3;
    localparam int unsigned CNT_W   = 4;

endpackage

// File: rtl/jmp_cond_eval.sv
// Combinational condition evaluator: condition code plus {C,S,Z} flags to a
// taken decision. Codes outside ALWAYS..GEU never jump.
module jmp_cond_eval
    import jmp_pkg::*;
(
    input  logic [3:0]         cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               taken_c
);

    logic s_flag;
    logic z_flag;
    logic c_flag;

    assign s_flag = flags[FLAG_S];
    assign z_flag = flags[FLAG_Z];
    assign c_flag = flags[FLAG_C];

    always_comb begin
        taken_c = 1'b0;
        case (cond_e'(cond))
            ALWAYS:  taken_c = 1'b1;
            LT:      taken_c = s_flag;
            LE:      taken_c = s_flag | z_flag;
            GT:      taken_c = ~s_flag & ~z_flag;
            GE:      taken_c = ~s_flag;
            EQ:      taken_c = z_flag;
            NE:      taken_c = ~z_flag;
            LTU:     taken_c = c_flag;
            GEU:     taken_c = ~c_flag;
            default: taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/jmp_ctrl_seq.sv
// Registered jump controller: flag register with optional forwarding,
// condition evaluation, PC-relative target and counted flush window.
module jmp_ctrl_seq
    import jmp_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned OFF_W        = 8,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned FWD_EN       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_we,
    input  logic              s_in,
    input  logic              z_in,
    input  logic              c_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        cond,
    input  logic [ADDR_W-1:0] pc,
    input  logic [OFF_W-1:0]  offset,
    output logic              jmp_en,
    output logic [ADDR_W-1:0] jmp_target,
    output logic              flush,
    output logic [2:0]        flags_q
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FLAGS_W-1:0]  flags_d;
    logic                jmp_en_q, jmp_en_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                flush_q, flush_d;
    logic                br_ready_q, br_ready_d;

    logic [FLAGS_W-1:0]  flags_in;
    logic [FLAGS_W-1:0]  flags_eff;
    logic [ADDR_W-1:0]   off_ext;
    logic                taken_c;
    logic                accept;

    assign flags_in  = {c_in, s_in, z_in};
    assign flags_eff = ((FWD_EN != 0) && flag_we) ? flags_in : flags_q;
    assign off_ext   = ADDR_W'($signed(offset));
    assign accept    = br_valid & br_ready_q;

    jmp_cond_eval u_cond_eval (
        .cond    (cond),
        .flags   (flags_eff),
        .taken_c (taken_c)
    );

    // Next state, counter and registered outputs; ready/flush decode the next state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flags_d    = flag_we ? flags_in : flags_q;
        jmp_en_d   = accept & taken_c;
        target_d   = accept ? (pc + off_ext) : target_q;

        case (state_q)
            IDLE: begin
                if (accept && taken_c && (FLUSH_CYCLES != 0)) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        flush_d    = (state_d == FLUSH);
        br_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            flags_q    <= '0;
            jmp_en_q   <= 1'b0;
            target_q   <= '0;
            flush_q    <= 1'b0;
            br_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flags_q    <= flags_d;
            jmp_en_q   <= jmp_en_d;
            target_q   <= target_d;
            flush_q    <= flush_d;
            br_ready_q <= br_ready_d;
        end
    end

    assign jmp_en     = jmp_en_q;
    assign jmp_target = target_q;
    assign flush      = flush_q;
    assign br_ready   = br_ready_q;

endmodule

// File: tb/tb_jmp_ctrl_seq.sv
// Directed bench for jmp_ctrl_seq: default instance (forwarding, 2-cycle flush)
// alongside a no-forwarding, no-flush instance driven by the same inputs.
module tb_jmp_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_we, s_in, z_in, c_in, br_valid;
    logic [3:0]  cond;
    logic [15:0] pc;
    logic [7:0]  offset;

    logic        br_ready0, jmp_en0, flush0;
    logic [15:0] tgt0;
    logic [2:0]  flags0;
    logic        br_ready1, jmp_en1, flush1;
    logic [15:0] tgt1;
    logic [2:0]  flags1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jmp_ctrl_seq dut0 (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .s_in(s_in), .z_in(z_in),
        .c_in(c_in), .br_valid(br_valid), .br_ready(br_ready0), .cond(cond),
        .pc(pc), .offset(offset), .jmp_en(jmp_en0), .jmp_target(tgt0),
        .flush(flush0), .flags_q(flags0)
    );

    jmp_ctrl_seq #(.FWD_EN(0), .FLUSH_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .s_in(s_in), .z_in(z_in),
        .c_in(c_in), .br_valid(br_valid), .br_ready(br_ready1), .cond(cond),
        .pc(pc), .offset(offset), .jmp_en(jmp_en1), .jmp_target(tgt1),
        .flush(flush1), .flags_q(flags1)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f;     // {C,S,Z}
        logic [3:0]  cond;
        logic [15:0] pc;
        logic [7:0]  off;
        logic        en0;   // forwarding instance
        logic        en1;   // non-forwarding instance
        logic [15:0] tgt;
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] f, input logic v,
                         input logic [3:0] c, input logic [15:0] p, input logic [7:0] o);
        flag_we  = we;
        c_in     = f[2];
        s_in     = f[1];
        z_in     = f[0];
        br_valid = v;
        cond     = c;
        pc       = p;
        offset   = o;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 4'd1,  16'h0200, 8'h04, 1'b1, 1'b0, 16'h0204, 3'b010};
        vecs[1]  = '{1'b1, 3'b001, 4'd5,  16'h0100, 8'h10, 1'b1, 1'b0, 16'h0110, 3'b001};
        vecs[2]  = '{1'b0, 3'b000, 4'd4,  16'hFFF8, 8'h10, 1'b1, 1'b1, 16'h0008, 3'b001};
        vecs[3]  = '{1'b0, 3'b000, 4'd2,  16'h0004, 8'hF8, 1'b1, 1'b1, 16'hFFFC, 3'b001};
        vecs[4]  = '{1'b1, 3'b100, 4'd7,  16'h1000, 8'h80, 1'b1, 1'b0, 16'h0F80, 3'b100};
        vecs[5]  = '{1'b0, 3'b000, 4'd8,  16'h1000, 8'h7F, 1'b0, 1'b0, 16'h107F, 3'b100};
        vecs[6]  = '{1'b1, 3'b000, 4'd3,  16'h0000, 8'h00, 1'b1, 1'b1, 16'h0000, 3'b000};
        vecs[7]  = '{1'b0, 3'b000, 4'd6,  16'h1234, 8'h01, 1'b1, 1'b1, 16'h1235, 3'b000};
        vecs[8]  = '{1'b1, 3'b111, 4'd0,  16'hABCD, 8'hFF, 1'b1, 1'b1, 16'hABCC, 3'b111};
        vecs[9]  = '{1'b0, 3'b000, 4'd15, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 3'b111};
        vecs[10] = '{1'b0, 3'b000, 4'd3,  16'h0010, 8'hF0, 1'b0, 1'b0, 16'h0000, 3'b111};
        vecs[11] = '{1'b1, 3'b001, 4'd6,  16'h0050, 8'h05, 1'b0, 1'b0, 16'h0055, 3'b001};

        drive(1'b0, 3'b000, 1'b0, 4'd0, 16'h0000, 8'h00);
        rst_n = 1'b0;
        #12;
        chk("rst_flags",    32'(flags0),    32'h0);
        chk("rst_jmp_en",   32'(jmp_en0),   32'h0);
        chk("rst_target",   32'(tgt0),      32'h0);
        chk("rst_flush",    32'(flush0),    32'h0);
        chk("rst_br_ready", 32'(br_ready0), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table vectors: one branch each, then let any flush window drain
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].we, vecs[i].f, 1'b1, vecs[i].cond, vecs[i].pc, vecs[i].off);
            step();
            chk($sformatf("v%0d_jmp_en_fwd", i),   32'(jmp_en0),   32'(vecs[i].en0));
            chk($sformatf("v%0d_jmp_en_nofwd", i), 32'(jmp_en1),   32'(vecs[i].en1));
            chk($sformatf("v%0d_target", i),       32'(tgt0),      32'(vecs[i].tgt));
            chk($sformatf("v%0d_target_nofwd", i), 32'(tgt1),      32'(vecs[i].tgt));
            chk($sformatf("v%0d_flags", i),        32'(flags0),    32'(vecs[i].flg));
            chk($sformatf("v%0d_flags_nofwd", i),  32'(flags1),    32'(vecs[i].flg));
            chk($sformatf("v%0d_flush", i),        32'(flush0),    32'(vecs[i].en0));
            chk($sformatf("v%0d_br_ready", i),     32'(br_ready0), 32'(!vecs[i].en0));
            drive(1'b0, 3'b000, 1'b0, 4'd0, 16'h0000, 8'h00);
            step();
            chk($sformatf("v%0d_pulse_end", i), 32'(jmp_en0), 32'h0);
            step();
        end

        // Taken EQ branch, then a second request held through the flush window
        drive(1'b1, 3'b001, 1'b0, 4'd0, 16'h0000, 8'h00);
        step();
        drive(1'b0, 3'b000, 1'b1, 4'd5, 16'h0100, 8'h10);
        step();
        chk("win_jmp_en",   32'(jmp_en0),   32'h1);
        chk("win_target",   32'(tgt0),      32'h0110);
        chk("win_flush1",   32'(flush0),    32'h1);
        chk("win_ready1",   32'(br_ready0), 32'h0);
        drive(1'b0, 3'b000, 1'b1, 4'd6, 16'h0300, 8'h20);
        step();
        chk("win_jmp_en2",  32'(jmp_en0),   32'h0);
        chk("win_flush2",   32'(flush0),    32'h1);
        chk("win_ready2",   32'(br_ready0), 32'h0);
        chk("win_hold_tgt", 32'(tgt0),      32'h0110);
        step();
        chk("win_flush3",   32'(flush0),    32'h0);
        chk("win_ready3",   32'(br_ready0), 32'h1);
        chk("win_ignored",  32'(tgt0),      32'h0110);
        step();
        chk("win_accept_tgt", 32'(tgt0),    32'h0320);
        chk("win_accept_en",  32'(jmp_en0), 32'h0);
        drive(1'b0, 3'b000, 1'b0, 4'd0, 16'h0000, 8'h00);
        step();

        // Zero-length flush instance takes back-to-back ALWAYS branches
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'b000, 1'b1, 4'd0, 16'(16'h2000 + i * 16'h0100), 8'h02);
            step();
            chk($sformatf("b2b_taken_en%0d", i),    32'(jmp_en1),   32'h1);
            chk($sformatf("b2b_taken_flush%0d", i), 32'(flush1),    32'h0);
            chk($sformatf("b2b_taken_ready%0d", i), 32'(br_ready1), 32'h1);
            chk($sformatf("b2b_taken_tgt%0d", i),   32'(tgt1),      32'(16'h2002 + i * 16'h0100));
        end
        drive(1'b1, 3'b001, 1'b0, 4'd0, 16'h0000, 8'h00);
        step();
        drive(1'b0, 3'b000, 1'b0, 4'd0, 16'h0000, 8'h00);
        step();
        step();

        // Back-to-back not-taken NE with Z set
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'b000, 1'b1, 4'd6, 16'(16'h0400 + i * 16'h0010), 8'h01);
            step();
            chk($sformatf("b2b_nt_ready%0d", i), 32'(br_ready0), 32'h1);
            chk($sformatf("b2b_nt_en%0d", i),    32'(jmp_en0),   32'h0);
            chk($sformatf("b2b_nt_tgt%0d", i),   32'(tgt0),      32'(16'h0401 + i * 16'h0010));
        end

        // Reserved codes never jump, whatever the flags
        for (int c = 9; c < 16; c++) begin
            for (int f = 0; f < 8; f++) begin
                drive(1'b1, 3'(f), 1'b1, 4'(c), 16'h0000, 8'h00);
                step();
                chk($sformatf("rsv_c%0d_f%0d", c, f),       32'(jmp_en0),   32'h0);
                chk($sformatf("rsv_nofwd_c%0d_f%0d", c, f), 32'(jmp_en1),   32'h0);
                chk($sformatf("rsv_ready_c%0d_f%0d", c, f), 32'(br_ready0), 32'h1);
            end
        end

        // Reset in the first flush cycle
        drive(1'b1, 3'b111, 1'b1, 4'd0, 16'h0800, 8'h08);
        step();
        drive(1'b0, 3'b000, 1'b0, 4'd0, 16'h0000, 8'h00);
        chk("mid_flush_pre", 32'(flush0), 32'h1);
        chk("mid_flags_pre", 32'(flags0), 32'h7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flush",  32'(flush0),    32'h0);
        chk("mid_rst_jmp_en", 32'(jmp_en0),   32'h0);
        chk("mid_rst_flags",  32'(flags0),    32'h0);
        chk("mid_rst_target", 32'(tgt0),      32'h0);
        chk("mid_rst_ready",  32'(br_ready0), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(br_ready0), 32'h1);
        chk("post_rst_flush", 32'(flush0),    32'h0);
        chk("post_rst_en",    32'(jmp_en0),   32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
